// File: rtl/baud_tick_ctrl.sv
// baud_tick_ctrl
// Baud-rate scheduler for the UART subsystem. It produces single-cycle clock
// enables on clk_i instead of divided clocks:
//   rx_tick_o at OVERSAMPLE x baud (receiver sampling)
//   tx_tick_o at baud, always on the same cycle as an rx_tick_o
// Baud changes arrive over a valid/ready handshake. They are only applied
// between transmit frames, so a frame in flight is never stretched or cut.
//
// Optional build macro BAUD_TICK_DBG_EN adds tick_cnt_o, a 16-bit wrapping
// count of tx ticks. It is cleared by reset and whenever a new rate is loaded.
module baud_tick_ctrl #(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned DEFAULT_SEL = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        cfg_valid_i,
  input  logic [2:0]  cfg_sel_i,
  output logic        cfg_ready_o,
  input  logic        busy_tx_i,
  output logic        rx_tick_o,
  output logic        tx_tick_o,
  output logic [2:0]  active_sel_o,
  output logic        locked_o
`ifdef BAUD_TICK_DBG_EN
  ,
  output logic [15:0] tick_cnt_o
`endif
);

  // Width of the oversample counter. It is kept at least one bit wide so that
  // a bad OVERSAMPLE value reaches the readable elaboration error below.
  localparam int unsigned OS_W = (OVERSAMPLE < 2) ? 1 : $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [2:0]      RESET_SEL = 3'(DEFAULT_SEL);

  // Clocks per rx tick for one baud index: round to nearest, never below 2.
  function automatic longint unsigned calcDiv(input int unsigned sel);
    longint unsigned baud;
    longint unsigned den;
    longint unsigned q;
    case (sel)
      0:       baud = 64'd1200;
      1:       baud = 64'd2400;
      2:       baud = 64'd4800;
      3:       baud = 64'd9600;
      4:       baud = 64'd19200;
      5:       baud = 64'd38400;
      6:       baud = 64'd57600;
      default: baud = 64'd115200;
    endcase
    den = baud * 64'(OVERSAMPLE);
    q   = (64'(CLK_FREQ) + den / 64'd2) / den;
    if (q < 64'd2) begin
      q = 64'd2;
    end
    return q;
  endfunction

  // Terminal count (DIV-1) for every baud index, fixed at elaboration.
  localparam logic [15:0] DIV_M1 [8] = '{
    16'(calcDiv(0) - 64'd1),
    16'(calcDiv(1) - 64'd1),
    16'(calcDiv(2) - 64'd1),
    16'(calcDiv(3) - 64'd1),
    16'(calcDiv(4) - 64'd1),
    16'(calcDiv(5) - 64'd1),
    16'(calcDiv(6) - 64'd1),
    16'(calcDiv(7) - 64'd1)
  };

  // The rx divider is 16 bits wide. A clock/oversample combination that needs
  // more than that stops elaboration instead of silently truncating.
  for (genvar g = 0; g < 8; g++) begin : g_divCheck
    if (calcDiv(g) > 64'd65535) begin : g_tooBig
      $error("baud_tick_ctrl: divider for baud index %0d exceeds 16 bits", g);
    end
  end

  if (OVERSAMPLE < 2) begin : g_osCheck
    $error("baud_tick_ctrl: OVERSAMPLE must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PEND,
    LOAD
  } state_e;

  state_e          state_q,     state_d;
  logic [15:0]     rxCnt_q,     rxCnt_d;
  logic [OS_W-1:0] osCnt_q,     osCnt_d;
  logic [2:0]      activeSel_q, activeSel_d;
  logic [2:0]      pendSel_q,   pendSel_d;
  logic            locked_q,    locked_d;

  logic        counting;
  logic        rxTick;
  logic        txTick;
  logic        cfgReady;
  logic        handshake;
  logic        newSel;
  logic [15:0] divLast;

  // Tick generation and handshake qualification, derived from the current state.
  // Ticks are gated by enable_i so that no tick escapes on the cycle enable falls.
  always_comb begin
    divLast   = DIV_M1[activeSel_q];
    counting  = ((state_q == RUN) || (state_q == PEND)) && enable_i;
    rxTick    = counting && (rxCnt_q >= divLast);
    txTick    = rxTick && (osCnt_q == OS_LAST);
    cfgReady  = !rst_i && ((state_q == IDLE) || (state_q == RUN));
    handshake = cfg_valid_i && cfgReady;
    newSel    = handshake && (cfg_sel_i != activeSel_q);
  end

  // Divider chain and lock flag. The counters only run while ticking is active;
  // every other situation (idle, load, enable dropping) returns them to zero,
  // so each new run starts a full period from scratch.
  always_comb begin
    rxCnt_d  = '0;
    osCnt_d  = '0;
    locked_d = 1'b0;
    if (counting) begin
      locked_d = locked_q | txTick;
      if (rxTick) begin
        rxCnt_d = '0;
        if (txTick) begin
          osCnt_d = '0;
        end else begin
          osCnt_d = osCnt_q + OS_W'(1);
        end
      end else begin
        rxCnt_d = rxCnt_q + 16'd1;
        osCnt_d = osCnt_q;
      end
    end
  end

  // Rate-change sequencing. A different baud index is parked in PEND until the
  // transmitter is between frames, then applied in the single-cycle LOAD state.
  // When ticking is stopped there is no frame to protect, so changes apply at once.
  always_comb begin
    state_d     = state_q;
    activeSel_d = activeSel_q;
    pendSel_d   = pendSel_q;
    case (state_q)
      IDLE: begin
        if (newSel) begin
          activeSel_d = cfg_sel_i;
        end
        if (enable_i) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!enable_i) begin
          state_d = IDLE;
          if (newSel) begin
            activeSel_d = cfg_sel_i;
          end
        end else if (newSel) begin
          pendSel_d = cfg_sel_i;
          state_d   = PEND;
        end
      end
      PEND: begin
        if (!enable_i) begin
          state_d     = IDLE;
          activeSel_d = pendSel_q;
        end else if (!busy_tx_i) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        activeSel_d = pendSel_q;
        state_d     = enable_i ? RUN : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset; a pending request is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      rxCnt_q     <= '0;
      osCnt_q     <= '0;
      activeSel_q <= RESET_SEL;
      pendSel_q   <= RESET_SEL;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rxCnt_q     <= rxCnt_d;
      osCnt_q     <= osCnt_d;
      activeSel_q <= activeSel_d;
      pendSel_q   <= pendSel_d;
      locked_q    <= locked_d;
    end
  end

`ifdef BAUD_TICK_DBG_EN
  logic [15:0] tickCnt_q, tickCnt_d;

  // Debug count of tx ticks at the current rate; restarts whenever a rate is loaded.
  always_comb begin
    tickCnt_d = tickCnt_q;
    if (state_q == LOAD) begin
      tickCnt_d = '0;
    end else if (txTick) begin
      tickCnt_d = tickCnt_q + 16'd1;
    end
  end

  // Debug counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tickCnt_q <= '0;
    end else begin
      tickCnt_q <= tickCnt_d;
    end
  end

  assign tick_cnt_o = tickCnt_q;
`endif

  assign cfg_ready_o  = cfgReady;
  assign rx_tick_o    = rxTick;
  assign tx_tick_o    = txTick;
  assign active_sel_o = activeSel_q;
  assign locked_o     = locked_q;

endmodule

// File: tb/tb_baud_tick_ctrl.sv
// tb_baud_tick_ctrl
// Self-checking bench for baud_tick_ctrl. A cycle-level reference model derives
// tick times arithmetically from "clocks since the run started" and is compared
// with the DUT on every falling edge. Directed sequences add hand-computed
// interval checks (326 / 27 / 2604 clocks, 5216 / 432 clocks per tx tick).
// Build with BAUD_TICK_DBG_EN defined to also check tick_cnt_o.
module tb_baud_tick_ctrl;

  localparam int CLK_FREQ = 50_000_000;
  localparam int OS       = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       cfgValid = 1'b0;
  logic [2:0] cfgSel = 3'd0;
  logic       busyTx = 1'b0;
  logic       cfgReady;
  logic       rxTick;
  logic       txTick;
  logic [2:0] activeSel;
  logic       locked;
`ifdef BAUD_TICK_DBG_EN
  logic [15:0] tickCnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  baud_tick_ctrl #(
    .CLK_FREQ   (CLK_FREQ),
    .OVERSAMPLE (OS),
    .DEFAULT_SEL(3)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .enable_i    (enable),
    .cfg_valid_i (cfgValid),
    .cfg_sel_i   (cfgSel),
    .cfg_ready_o (cfgReady),
    .busy_tx_i   (busyTx),
    .rx_tick_o   (rxTick),
    .tx_tick_o   (txTick),
    .active_sel_o(activeSel),
    .locked_o    (locked)
`ifdef BAUD_TICK_DBG_EN
    ,
    .tick_cnt_o  (tickCnt)
`endif
  );

  // One comparison: counts it, reports it on mismatch (X counts as a mismatch).
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
    end
  endtask

  // Clocks per rx tick from the baud table, rounded to nearest, minimum 2.
  function automatic int modelDiv(input int sel);
    int bauds[8] = '{1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200};
    int den;
    int q;
    den = bauds[sel] * OS;
    q   = (CLK_FREQ + den / 2) / den;
    return (q < 2) ? 2 : q;
  endfunction

  // Reference model state: operating mode, selections, and the cycle index on
  // which the current run began (ticks fall on multiples of DIV since then).
  typedef enum int {M_IDLE, M_RUN, M_PEND, M_LOAD} mode_t;
  mode_t mMode   = M_IDLE;
  int    mSel    = 3;
  int    mPend   = 0;
  int    mStart  = 0;
  int    cyc     = 0;
  bit    mLocked = 1'b0;
  int    mTicks  = 0;

  int mDiv;
  int mN;
  bit mCounting;
  bit expRx;
  bit expTx;
  bit expReady;
  bit mHs;
  bit mDiff;

  // Per-cycle compare against the model, then advance the model by one clock.
  always @(negedge clk) begin
    mDiv      = modelDiv(mSel);
    mN        = cyc - mStart + 1;
    mCounting = ((mMode == M_RUN) || (mMode == M_PEND)) && enable;
    expRx     = mCounting && ((mN % mDiv) == 0);
    expTx     = expRx && ((mN % (mDiv * OS)) == 0);
    expReady  = !rst && ((mMode == M_IDLE) || (mMode == M_RUN));
    mHs       = cfgValid && expReady;
    mDiff     = mHs && (int'(cfgSel) != mSel);

    checkOutput("rx_tick", 32'(rxTick), 32'(expRx));
    checkOutput("tx_tick", 32'(txTick), 32'(expTx));
    checkOutput("cfg_ready", 32'(cfgReady), 32'(expReady));
    checkOutput("active_sel", 32'(activeSel), mSel);
    checkOutput("locked", 32'(locked), 32'(mLocked));
`ifdef BAUD_TICK_DBG_EN
    checkOutput("tick_cnt", 32'(tickCnt), mTicks);
`endif

    if (rst) begin
      mTicks = 0;
    end else if (mMode == M_LOAD) begin
      mTicks = 0;
    end else if (expTx) begin
      mTicks = (mTicks + 1) % 65536;
    end

    if (rst) begin
      mMode   = M_IDLE;
      mSel    = 3;
      mLocked = 1'b0;
    end else begin
      case (mMode)
        M_IDLE: begin
          mLocked = 1'b0;
          if (mDiff) mSel = int'(cfgSel);
          if (enable) begin
            mMode  = M_RUN;
            mStart = cyc + 1;
          end
        end
        M_RUN: begin
          if (!enable) begin
            mMode   = M_IDLE;
            mLocked = 1'b0;
            if (mDiff) mSel = int'(cfgSel);
          end else begin
            if (expTx) mLocked = 1'b1;
            if (mDiff) begin
              mPend = int'(cfgSel);
              mMode = M_PEND;
            end
          end
        end
        M_PEND: begin
          if (!enable) begin
            mMode   = M_IDLE;
            mLocked = 1'b0;
            mSel    = mPend;
          end else begin
            if (expTx) mLocked = 1'b1;
            if (!busyTx) mMode = M_LOAD;
          end
        end
        default: begin
          mSel    = mPend;
          mLocked = 1'b0;
          if (enable) begin
            mMode  = M_RUN;
            mStart = cyc + 1;
          end else begin
            mMode = M_IDLE;
          end
        end
      endcase
    end
    cyc++;
  end

  // Drive one set of inputs across exactly one rising edge; returns just after it.
  task automatic applyStimulus(input logic r, input logic e, input logic v,
                               input logic [2:0] s, input logic b);
    rst      = r;
    enable   = e;
    cfgValid = v;
    cfgSel   = s;
    busyTx   = b;
    @(posedge clk);
    #1;
  endtask

  // Count clocks, starting with the current one, until the chosen tick is seen.
  // Returns -1 if the budget runs out. Leaves the bench just after the next edge.
  task automatic waitTick(input bit wantTx, input int limit, output int cnt);
    cnt = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if ((wantTx ? txTick : rxTick) === 1'b1) begin
        cnt = i;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Global time bound so the run always ends with a summary line.
  initial begin
    #2_000_000;
    failures++;
    $display("[TB] FAIL watchdog: simulation time exceeded");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  int n;

  initial begin
    // Reset held for two clocks.
    applyStimulus(1, 0, 0, 3'd0, 0);
    applyStimulus(1, 0, 0, 3'd0, 0);
    #1;
    checkOutput("rst_cfg_ready", 32'(cfgReady), 0);
    checkOutput("rst_active_sel", 32'(activeSel), 3);
    checkOutput("rst_locked", 32'(locked), 0);
    checkOutput("rst_rx_tick", 32'(rxTick), 0);

    // Idle after reset, then run at the default rate.
    applyStimulus(0, 0, 0, 3'd0, 0);
    #1;
    checkOutput("idle_cfg_ready", 32'(cfgReady), 1);
    applyStimulus(0, 1, 0, 3'd0, 0);
    waitTick(0, 1000, n);
    checkOutput("sel3_first_rx", n, 326);
    waitTick(0, 1000, n);
    checkOutput("sel3_rx_period", n, 326);
    waitTick(1, 10000, n);
    waitTick(1, 10000, n);
    checkOutput("sel3_tx_period", n, 5216);
    #1;
    checkOutput("sel3_locked", 32'(locked), 1);
    checkOutput("sel3_active_sel", 32'(activeSel), 3);

    // Switch to 115200 with the transmitter idle: PEND, LOAD, then RUN.
    applyStimulus(0, 1, 1, 3'd7, 0);
    #1;
    checkOutput("sel7_pend_ready", 32'(cfgReady), 0);
    applyStimulus(0, 1, 0, 3'd7, 0);
    #1;
    checkOutput("sel7_load_ready", 32'(cfgReady), 0);
    applyStimulus(0, 1, 0, 3'd7, 0);
    #1;
    checkOutput("sel7_run_ready", 32'(cfgReady), 1);
    checkOutput("sel7_active_sel", 32'(activeSel), 7);
    checkOutput("sel7_locked", 32'(locked), 0);
    waitTick(0, 100, n);
    checkOutput("sel7_first_rx", n, 27);
    waitTick(1, 1000, n);
    waitTick(1, 1000, n);
    checkOutput("sel7_tx_period", n, 432);

    // Request 1200 while the transmitter is busy: old rate continues.
    applyStimulus(0, 1, 1, 3'd0, 1);
    applyStimulus(0, 1, 0, 3'd0, 1);
    #1;
    checkOutput("busy_pend_ready", 32'(cfgReady), 0);
    checkOutput("busy_active_sel", 32'(activeSel), 7);
    waitTick(0, 100, n);
    waitTick(0, 100, n);
    checkOutput("busy_old_rx_period", n, 27);
    applyStimulus(0, 1, 0, 3'd0, 0);
    #1;
    checkOutput("sel0_load_ready", 32'(cfgReady), 0);
    applyStimulus(0, 1, 0, 3'd0, 0);
    #1;
    checkOutput("sel0_active_sel", 32'(activeSel), 0);
    waitTick(0, 3000, n);
    checkOutput("sel0_first_rx", n, 2604);
    waitTick(0, 3000, n);
    checkOutput("sel0_rx_period", n, 2604);

    // Handshake with the active index: acknowledged, phase unchanged.
    applyStimulus(0, 1, 1, 3'd0, 0);
    #1;
    checkOutput("same_sel_ready", 32'(cfgReady), 1);
    applyStimulus(0, 1, 0, 3'd0, 0);
    waitTick(0, 3000, n);
    checkOutput("same_sel_phase", n, 2602);

    // Enable low for 10 clocks mid-period; change rate while idle.
    repeat (100) applyStimulus(0, 1, 0, 3'd0, 0);
    applyStimulus(0, 0, 0, 3'd0, 0);
    #1;
    checkOutput("idle_locked", 32'(locked), 0);
    applyStimulus(0, 0, 1, 3'd3, 0);
    #1;
    checkOutput("idle_direct_sel", 32'(activeSel), 3);
    repeat (8) applyStimulus(0, 0, 0, 3'd3, 0);
    applyStimulus(0, 1, 0, 3'd3, 0);
    waitTick(0, 1000, n);
    checkOutput("reenable_first_rx", n, 326);

    // Pending request applied on dropping enable.
    applyStimulus(0, 1, 1, 3'd6, 1);
    applyStimulus(0, 0, 0, 3'd6, 1);
    #1;
    checkOutput("pend_to_idle_sel", 32'(activeSel), 6);

    // Reset while a request for index 5 is pending.
    applyStimulus(0, 1, 0, 3'd6, 1);
    applyStimulus(0, 1, 1, 3'd5, 1);
    #1;
    checkOutput("rst_pend_ready", 32'(cfgReady), 0);
    applyStimulus(1, 1, 0, 3'd5, 1);
    #1;
    checkOutput("rst_pend_ready_in_rst", 32'(cfgReady), 0);
    checkOutput("rst_pend_active_sel", 32'(activeSel), 3);
`ifdef BAUD_TICK_DBG_EN
    checkOutput("rst_tick_cnt", 32'(tickCnt), 0);
`endif
    applyStimulus(0, 1, 0, 3'd5, 0);
    waitTick(0, 1000, n);
    checkOutput("post_rst_first_rx", n, 326);
    waitTick(0, 1000, n);
    checkOutput("post_rst_rx_period", n, 326);
    #1;
    checkOutput("post_rst_active_sel", 32'(activeSel), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
